// File: rtl/nfu_2_pipe_if.sv
// Bus between NFU-1 and NFU-2: product vector with pass flags in, per-neuron
// partial sums and status out.
interface nfu_2_pipe_if #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16
);
    localparam int TnxTn = Tn * Tn;

    logic                         i_valid;
    logic                         i_first;
    logic                         i_last;
    logic [BIT_WIDTH*TnxTn-1:0]   i_products;
    logic                         o_valid;
    logic [BIT_WIDTH*Tn-1:0]      o_results;
    logic                         o_busy;
    logic                         o_proto_err;

    modport master (
        output i_valid, i_first, i_last, i_products,
        input  o_valid, o_results, o_busy, o_proto_err
    );

    modport slave (
        input  i_valid, i_first, i_last, i_products,
        output o_valid, o_results, o_busy, o_proto_err
    );
endinterface

// File: rtl/nfu_2_pipe.sv
// NFU-2: per-neuron registered saturating adder tree followed by a saturating
// accumulator that sums tree outputs across the input tiles of a neuron pass.
module nfu_2_pipe #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int TnxTn     = 256,
    parameter int LOG2_TN   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    nfu_2_pipe_if.slave   bus
);
    localparam int BW    = BIT_WIDTH;
    localparam int NODES = Tn - 1;
    localparam logic signed [BW-1:0] MAX_VAL = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] MIN_VAL = {1'b1, {(BW-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} passState_t;

    function automatic logic signed [BW-1:0] satAdd(input logic signed [BW-1:0] a,
                                                     input logic signed [BW-1:0] b);
        logic [BW:0] sum;
        sum = {a[BW-1], a} + {b[BW-1], b};
        if (sum[BW] != sum[BW-1]) begin
            return sum[BW] ? MIN_VAL : MAX_VAL;
        end
        return sum[BW-1:0];
    endfunction

    // Tree nodes per neuron, level L (1-based) starts at index Tn - (Tn >> (L-1)).
    logic signed [BW-1:0] treeNode [Tn][NODES];
    logic signed [BW-1:0] treeSum  [Tn];
    logic [LOG2_TN-1:0]   validPipe;
    logic [LOG2_TN-1:0]   firstPipe;
    logic [LOG2_TN-1:0]   lastPipe;
    logic signed [BW-1:0] acc      [Tn];
    logic signed [BW-1:0] newAcc   [Tn];
    logic [BW*Tn-1:0]     resultsReg;
    logic                 validReg;
    logic                 errReg;
    passState_t           state;
    passState_t           nextState;
    logic                 beat;
    logic                 alignedFirst;
    logic                 alignedLast;
    logic                 startPass;
    logic                 protoErrSet;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < Tn; n++) begin
                for (int i = 0; i < NODES; i++) begin
                    treeNode[n][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < TnxTn / 2; p++) begin
                treeNode[p / (Tn / 2)][p % (Tn / 2)] <=
                    satAdd(bus.i_products[2*p*BW +: BW], bus.i_products[(2*p+1)*BW +: BW]);
            end
            for (int n = 0; n < Tn; n++) begin
                for (int lvl = 2; lvl <= LOG2_TN; lvl++) begin
                    for (int j = 0; j < (Tn >> lvl); j++) begin
                        treeNode[n][Tn - (Tn >> (lvl-1)) + j] <=
                            satAdd(treeNode[n][Tn - (Tn >> (lvl-2)) + 2*j],
                                   treeNode[n][Tn - (Tn >> (lvl-2)) + 2*j + 1]);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < Tn; n++) begin
            treeSum[n] = treeNode[n][NODES-1];
        end
    end

    // Flags travel beside the tree so they reach the accumulator with their sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe <= '0;
            firstPipe <= '0;
            lastPipe  <= '0;
        end else begin
            validPipe[0] <= bus.i_valid;
            firstPipe[0] <= bus.i_first;
            lastPipe[0]  <= bus.i_last;
            for (int i = 1; i < LOG2_TN; i++) begin
                validPipe[i] <= validPipe[i-1];
                firstPipe[i] <= firstPipe[i-1];
                lastPipe[i]  <= lastPipe[i-1];
            end
        end
    end

    assign beat         = validPipe[LOG2_TN-1];
    assign alignedFirst = firstPipe[LOG2_TN-1];
    assign alignedLast  = lastPipe[LOG2_TN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A beat arriving in IDLE always opens a pass; a stray first in ACCUM restarts it.
    always_comb begin
        nextState   = state;
        startPass   = 1'b0;
        protoErrSet = 1'b0;
        if (beat) begin
            nextState = alignedLast ? IDLE : ACCUM;
            if (state == IDLE) begin
                startPass   = 1'b1;
                protoErrSet = !alignedFirst;
            end else if (alignedFirst) begin
                startPass   = 1'b1;
                protoErrSet = 1'b1;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < Tn; n++) begin
            newAcc[n] = startPass ? treeSum[n] : satAdd(acc[n], treeSum[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < Tn; n++) begin
                acc[n] <= '0;
            end
            resultsReg <= '0;
            validReg   <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            validReg <= beat && alignedLast;
            if (protoErrSet) begin
                errReg <= 1'b1;
            end
            if (beat) begin
                for (int n = 0; n < Tn; n++) begin
                    acc[n] <= newAcc[n];
                    if (alignedLast) begin
                        resultsReg[n*BW +: BW] <= newAcc[n];
                    end
                end
            end
        end
    end

    assign bus.o_valid     = validReg;
    assign bus.o_results   = resultsReg;
    assign bus.o_busy      = (state == ACCUM);
    assign bus.o_proto_err = errReg;
endmodule

// File: tb/tb_nfu_2_pipe.sv
// Self-checking bench for nfu_2_pipe: a per-beat arithmetic model checked every
// cycle, plus directed scenarios with hand-computed lane values.
module tb_nfu_2_pipe;
    localparam int BW  = 16;
    localparam int TN  = 16;
    localparam int LAT = 5;
    localparam int PW  = BW * TN * TN;
    localparam int RW  = BW * TN;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    nfu_2_pipe_if #(.BIT_WIDTH(BW), .Tn(TN)) bus ();

    nfu_2_pipe #(.BIT_WIDTH(BW), .Tn(TN), .TnxTn(TN*TN), .LOG2_TN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic          f;
        logic          l;
        logic [RW-1:0] sums;
    } beatT;

    function automatic int satInt(input int x);
        int hi;
        int lo;
        hi = (1 << (BW-1)) - 1;
        lo = -(1 << (BW-1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic [RW-1:0] treeSums(input logic [PW-1:0] p);
        logic [RW-1:0] r;
        int vals [TN];
        r = '0;
        for (int n = 0; n < TN; n++) begin
            for (int k = 0; k < TN; k++) begin
                vals[k] = int'($signed(p[(n*TN+k)*BW +: BW]));
            end
            for (int w = TN / 2; w >= 1; w = w / 2) begin
                for (int j = 0; j < w; j++) begin
                    vals[j] = satInt(vals[2*j] + vals[2*j+1]);
                end
            end
            r[n*BW +: BW] = vals[0][BW-1:0];
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] fillAll(input logic [BW-1:0] v);
        logic [PW-1:0] r;
        for (int k = 0; k < TN*TN; k++) r[k*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [PW-1:0] fillByNeuron();
        logic [PW-1:0] r;
        for (int n = 0; n < TN; n++)
            for (int k = 0; k < TN; k++) r[(n*TN+k)*BW +: BW] = BW'(n);
        return r;
    endfunction

    function automatic logic [PW-1:0] fillMixed();
        logic [PW-1:0] r;
        for (int k = 0; k < TN*TN; k++) r[k*BW +: BW] = (k % 2 == 0) ? 16'h7FFF : 16'hFFFF;
        return r;
    endfunction

    function automatic logic [RW-1:0] lanesAll(input logic [BW-1:0] v);
        logic [RW-1:0] r;
        for (int n = 0; n < TN; n++) r[n*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] lanes48();
        logic [RW-1:0] r;
        for (int n = 0; n < TN; n++) r[n*BW +: BW] = BW'(48 * n);
        return r;
    endfunction

    task automatic cmp(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: each pass advances by whole beats, outputs appear LAT edges after capture.
    beatT          pipeQ [$];
    int            mAcc [TN];
    logic [RW-1:0] mRes;
    logic          mValid;
    logic          mBusy;
    logic          mErr;

    always @(posedge clk or negedge rst_n) begin
        beatT b;
        logic start;
        if (!rst_n) begin
            pipeQ.delete();
            for (int n = 0; n < TN; n++) mAcc[n] = 0;
            mRes   = '0;
            mValid = 1'b0;
            mBusy  = 1'b0;
            mErr   = 1'b0;
        end else begin
            b.v    = bus.i_valid;
            b.f    = bus.i_first;
            b.l    = bus.i_last;
            b.sums = treeSums(bus.i_products);
            pipeQ.push_back(b);
            mValid = 1'b0;
            if (pipeQ.size() == LAT) begin
                b = pipeQ.pop_front();
                if (b.v) begin
                    start = b.f || !mBusy;
                    if (b.f == mBusy) mErr = 1'b1;
                    for (int n = 0; n < TN; n++) begin
                        if (start) mAcc[n] = int'($signed(b.sums[n*BW +: BW]));
                        else       mAcc[n] = satInt(mAcc[n] + int'($signed(b.sums[n*BW +: BW])));
                    end
                    if (b.l) begin
                        for (int n = 0; n < TN; n++) mRes[n*BW +: BW] = mAcc[n][BW-1:0];
                        mValid = 1'b1;
                    end
                    mBusy = !b.l;
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp("model o_valid", RW'(bus.o_valid), RW'(mValid));
        cmp("model o_results", bus.o_results, mRes);
        cmp("model o_busy", RW'(bus.o_busy), RW'(mBusy));
        cmp("model o_proto_err", RW'(bus.o_proto_err), RW'(mErr));
    end

    task automatic applyStimulus(input logic v, input logic f, input logic l, input logic [PW-1:0] p);
        bus.i_valid    = v;
        bus.i_first    = f;
        bus.i_last     = l;
        bus.i_products = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [RW-1:0] expRes,
                               input logic expBusy, input logic expErr);
        cmp({name, " valid"}, RW'(bus.o_valid), RW'(expValid));
        cmp({name, " results"}, bus.o_results, expRes);
        cmp({name, " busy"}, RW'(bus.o_busy), RW'(expBusy));
        cmp({name, " err"}, RW'(bus.o_proto_err), RW'(expErr));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_first    = 1'b0;
        bus.i_last     = 1'b0;
        bus.i_products = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b1, 1'b1, fillAll(16'd1));
        idle(4);
        checkOutput("single ones", 1'b1, lanesAll(16'h0010), 1'b0, 1'b0);
        idle(1);
        checkOutput("single hold", 1'b0, lanesAll(16'h0010), 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, fillByNeuron());
        applyStimulus(1'b1, 1'b0, 1'b0, fillByNeuron());
        applyStimulus(1'b1, 1'b0, 1'b1, fillByNeuron());
        idle(2);
        checkOutput("three busy", 1'b0, lanesAll(16'h0010), 1'b1, 1'b0);
        idle(2);
        checkOutput("three tiles", 1'b1, lanes48(), 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, fillAll(16'h7FFF));
        idle(4);
        checkOutput("sat max", 1'b1, lanesAll(16'h7FFF), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, fillAll(16'h8000));
        idle(4);
        checkOutput("sat min", 1'b1, lanesAll(16'h8000), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, fillMixed());
        idle(4);
        checkOutput("sat mixed", 1'b1, lanesAll(16'h7FFF), 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, fillAll(16'd2));
        applyStimulus(1'b1, 1'b1, 1'b1, fillAll(16'd3));
        idle(3);
        checkOutput("b2b A", 1'b1, lanesAll(16'h0020), 1'b0, 1'b0);
        idle(1);
        checkOutput("b2b B", 1'b1, lanesAll(16'h0030), 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, fillAll(16'd1));
        idle(4);
        checkOutput("idle no first", 1'b1, lanesAll(16'h0010), 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, fillAll(16'd2));
        applyStimulus(1'b1, 1'b1, 1'b0, fillAll(16'd5));
        applyStimulus(1'b1, 1'b0, 1'b1, fillAll(16'd1));
        idle(4);
        checkOutput("restart mid pass", 1'b1, lanesAll(16'h0060), 1'b0, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b0, fillAll(16'd4));
        applyStimulus(1'b1, 1'b0, 1'b0, fillAll(16'd4));
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_first    = 1'b0;
        bus.i_last     = 1'b0;
        bus.i_products = '0;
        #1;
        checkOutput("reset mid pass", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        checkOutput("after reset quiet", 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, fillAll(16'd1));
        applyStimulus(1'b1, 1'b0, 1'b1, fillAll(16'd1));
        idle(4);
        checkOutput("clean pass", 1'b1, lanesAll(16'h0020), 1'b0, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/nfu_2_pipe.md
Name: nfu_2_pipe

Overview:
- NFU-2 stage. Sits directly downstream of NFU-1 and consumes its Tn x Tn product vector.
- For each of Tn output neurons, reduces that neuron's Tn products through a registered, saturating adder tree.
- Accumulates the tree sums across successive input tiles. Emits one Tn-wide partial-sum vector per neuron pass to NFU-3.
- No backpressure; tracks valid, first and last flags alongside the data pipeline.

Parameters:
- BIT_WIDTH, 16: width of each signed two's-complement fixed-point value.
- Tn, 16: neurons per tile and products per neuron; power of two, at least 2.
- TnxTn, 256: Tn*Tn, total product count.
- LOG2_TN, 4: log2(Tn), number of adder-tree levels.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  the product vector on i_products is valid this cycle.
- i_first  in  1  first tile of a neuron pass; qualified by i_valid.
- i_last  in  1  last tile of a neuron pass; qualified by i_valid.
- i_products  in  BIT_WIDTH*TnxTn  NFU-1 outputs. Neuron n owns bits [(n+1)*Tn*BIT_WIDTH-1 : n*Tn*BIT_WIDTH]. Product k of neuron n sits at offset k*BIT_WIDTH within that slice.
- o_valid  out  1  one-cycle pulse; o_results holds a completed pass.
- o_results  out  BIT_WIDTH*Tn  per-neuron sums. Neuron n at [(n+1)*BIT_WIDTH-1 : n*BIT_WIDTH].
- o_busy  out  1  high while a pass is open (state ACCUM).
- o_proto_err  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous): clear all tree registers, all pipeline valid/first/last flags, accumulators, o_results, o_valid, o_busy and o_proto_err to 0. State = IDLE.
- Reset asserted mid-pass discards the pass; no o_valid is produced for it.
- Adder tree, per neuron:
  - LOG2_TN registered levels. Level L adds adjacent pairs from level L-1; level 0 is the input products.
  - Every add is signed and saturating: clamp to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]. Widths do not grow.
  - Pair order is fixed: element 2j with element 2j+1.
- Flags i_valid, i_first and i_last ride a LOG2_TN-deep shift register aligned with the tree. The tree datapath may run unconditionally; only the flags gate state.
- Accumulate stage (one register level after the tree), on an aligned valid beat:
  - first = 1: acc[n] = tree_sum[n].
  - first = 0: acc[n] = sat(acc[n] + tree_sum[n]).
  - last = 1: o_results = the new acc value; o_valid = 1 for exactly one cycle.
- Latency: o_valid is asserted LOG2_TN+1 cycles after the i_valid beat carrying i_last. Default is 5.
- Throughput: one beat per cycle; back-to-back passes need no bubbles.
- o_results holds its value between o_valid pulses.
- State machine, evaluated on the aligned beat:
  - IDLE, first & !last -> ACCUM.
  - IDLE, first & last -> IDLE; single-tile pass; output = tree_sum.
  - ACCUM, !first & last -> IDLE; emit result.
  - ACCUM, !first & !last -> ACCUM.
  - IDLE, !first: treated as first (acc = tree_sum); set o_proto_err. Continue as the first-beat rules above.
  - ACCUM, first: discard the open acc; restart with acc = tree_sum; set o_proto_err.
  - Aligned valid = 0: no state or acc change.
- o_busy = (state == ACCUM).
- Tree outputs are not accumulated when the aligned valid is 0, i.e. during pipeline bubbles or fill.

Test Plan:
- Single tile, all products 1, first=last=1 -> 5 cycles later o_valid=1, every o_results lane = 16 (0x0010); o_busy never asserts.
- Three tiles, neuron n products all = n, flags first/-/last on consecutive cycles -> one o_valid pulse; lane n = 48n; o_busy high for 2 cycles.
- Saturation: all products 0x7FFF, one tile -> every lane 0x7FFF. All products 0x8000 -> every lane 0x8000. Mixed +0x7FFF/-1 pairs -> 0x7FFE per pair, then saturates to 0x7FFF at the next level.
- Back-to-back passes: single-tile pass A (products 2) on cycle t, pass B (products 3) on t+1 -> o_valid on t+5 (lanes 32) and t+6 (lanes 48).
- Protocol: a beat with first=0 while IDLE -> o_proto_err=1 and the sum still matches a first-beat result. A first beat mid-pass -> the old acc is dropped and o_proto_err stays 1.
- Reset mid-pass: assert rst_n=0 two cycles after a first beat -> all outputs 0 immediately; no o_valid afterwards. A subsequent clean pass produces correct sums.
